// File: rtl/jpeg_enc_coef_pack.sv
// Run-length packer: takes rows of eight 9-bit quantised coefficients and emits
// HDR/LO pairs, ZRL and EOB bytes plus an end-of-stream token as one byte stream.
module jpeg_enc_coef_pack #(
    parameter int ROWS_PER_BLOCK = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] inA_d,
    input  logic [8:0] inB_d,
    input  logic [8:0] inC_d,
    input  logic [8:0] inD_d,
    input  logic [8:0] inE_d,
    input  logic [8:0] inF_d,
    input  logic [8:0] inG_d,
    input  logic [8:0] inH_d,
    input  logic       inA_e,
    input  logic       inB_e,
    input  logic       inC_e,
    input  logic       inD_e,
    input  logic       inE_e,
    input  logic       inF_e,
    input  logic       inG_e,
    input  logic       inH_e,
    input  logic       inA_v,
    input  logic       inB_v,
    input  logic       inC_v,
    input  logic       inD_v,
    input  logic       inE_v,
    input  logic       inF_v,
    input  logic       inG_v,
    input  logic       inH_v,
    output logic       inA_b,
    output logic       inB_b,
    output logic       inC_b,
    output logic       inD_b,
    output logic       inE_b,
    output logic       inF_b,
    output logic       inG_b,
    output logic       inH_b,
    output logic [7:0] out_d,
    output logic       out_e,
    output logic       out_v,
    input  logic       out_b
);
    localparam int ROW_W = (ROWS_PER_BLOCK > 1) ? $clog2(ROWS_PER_BLOCK) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_SCAN,
        S_ZRL,
        S_HDR,
        S_LO,
        S_EOB,
        S_END
    } state_t;

    state_t           r_state, w_state_next;
    logic [ROW_W-1:0] r_row, w_row_next;
    logic [5:0]       r_run, w_run_next;
    logic [2:0]       r_idx, w_idx_next;
    logic             r_end_pend, w_end_pend_next;
    logic [7:0]       r_out_d, w_out_d_next;
    logic             r_out_e, w_out_e_next;
    logic             r_out_v, w_out_v_next;

    logic [8:0] w_in_d [8];
    logic [8:0] w_lane_coef [8];
    logic [8:0] w_coef;
    logic [7:0] w_in_v;
    logic       w_all_v;
    logic       w_take;
    logic       w_out_free;
    logic       w_unused;

    assign w_in_d[0] = inA_d;
    assign w_in_d[1] = inB_d;
    assign w_in_d[2] = inC_d;
    assign w_in_d[3] = inD_d;
    assign w_in_d[4] = inE_d;
    assign w_in_d[5] = inF_d;
    assign w_in_d[6] = inG_d;
    assign w_in_d[7] = inH_d;
    assign w_in_v    = {inH_v, inG_v, inF_v, inE_v, inD_v, inC_v, inB_v, inA_v};

    // Only lane A carries the end-of-stream marker; the other flags are don't-care.
    assign w_unused = &{1'b0, inB_e, inC_e, inD_e, inE_e, inF_e, inG_e, inH_e};

    assign w_all_v = &w_in_v;
    assign w_take  = (r_state == S_COLLECT) && w_all_v && !reset;

    assign inA_b = !w_take;
    assign inB_b = !w_take;
    assign inC_b = !w_take;
    assign inD_b = !w_take;
    assign inE_b = !w_take;
    assign inF_b = !w_take;
    assign inG_b = !w_take;
    assign inH_b = !w_take;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            logic [8:0] r_coef;
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_coef <= '0;
                end else if (w_take && !inA_e) begin
                    r_coef <= w_in_d[gi];
                end
            end
            assign w_lane_coef[gi] = r_coef;
        end
    endgenerate

    assign w_coef     = w_lane_coef[r_idx];
    assign w_out_free = !r_out_v || !out_b;

    always_comb begin
        w_state_next    = r_state;
        w_row_next      = r_row;
        w_run_next      = r_run;
        w_idx_next      = r_idx;
        w_end_pend_next = r_end_pend;
        w_out_d_next    = r_out_d;
        w_out_e_next    = r_out_e;
        w_out_v_next    = r_out_v && out_b;

        case (r_state)
            S_COLLECT: begin
                if (w_take) begin
                    if (inA_e) begin
                        if (r_row != '0) begin
                            w_state_next    = S_EOB;
                            w_end_pend_next = 1'b1;
                        end else begin
                            w_state_next = S_END;
                        end
                    end else begin
                        w_state_next = S_SCAN;
                        w_idx_next   = 3'd0;
                    end
                end
            end
            S_SCAN: begin
                if (w_coef == 9'd0) begin
                    // Saturate: a run can never exceed 63 within one 64-coefficient block.
                    w_run_next = (r_run == 6'd63) ? 6'd63 : r_run + 6'd1;
                    if (r_idx == 3'd7) begin
                        w_idx_next = 3'd0;
                        if (r_row == LAST_ROW) begin
                            w_state_next = S_EOB;
                        end else begin
                            w_row_next   = r_row + 1'b1;
                            w_state_next = S_COLLECT;
                        end
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end else if (r_run >= 6'd16) begin
                    w_state_next = S_ZRL;
                end else begin
                    w_state_next = S_HDR;
                end
            end
            S_ZRL: begin
                if (w_out_free) begin
                    w_out_v_next = 1'b1;
                    w_out_e_next = 1'b0;
                    w_out_d_next = 8'hF0;
                    w_run_next   = r_run - 6'd16;
                    w_state_next = (r_run < 6'd32) ? S_HDR : S_ZRL;
                end
            end
            S_HDR: begin
                if (w_out_free) begin
                    w_out_v_next = 1'b1;
                    w_out_e_next = 1'b0;
                    w_out_d_next = {r_run[3:0], 3'b100, w_coef[8]};
                    w_state_next = S_LO;
                end
            end
            S_LO: begin
                if (w_out_free) begin
                    w_out_v_next = 1'b1;
                    w_out_e_next = 1'b0;
                    w_out_d_next = w_coef[7:0];
                    w_run_next   = 6'd0;
                    if (r_idx == 3'd7) begin
                        w_idx_next = 3'd0;
                        if (r_row == LAST_ROW) begin
                            w_state_next = S_EOB;
                        end else begin
                            w_row_next   = r_row + 1'b1;
                            w_state_next = S_COLLECT;
                        end
                    end else begin
                        w_idx_next   = r_idx + 3'd1;
                        w_state_next = S_SCAN;
                    end
                end
            end
            S_EOB: begin
                if (w_out_free) begin
                    w_out_v_next    = 1'b1;
                    w_out_e_next    = 1'b0;
                    w_out_d_next    = 8'h00;
                    w_run_next      = 6'd0;
                    w_row_next      = '0;
                    w_end_pend_next = 1'b0;
                    w_state_next    = r_end_pend ? S_END : S_COLLECT;
                end
            end
            S_END: begin
                if (w_out_free) begin
                    w_out_v_next = 1'b1;
                    w_out_e_next = 1'b1;
                    w_out_d_next = 8'h00;
                    w_state_next = S_COLLECT;
                end
            end
            default: begin
                w_state_next = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_COLLECT;
            r_row      <= '0;
            r_run      <= 6'd0;
            r_idx      <= 3'd0;
            r_end_pend <= 1'b0;
            r_out_d    <= 8'h00;
            r_out_e    <= 1'b0;
            r_out_v    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_row      <= w_row_next;
            r_run      <= w_run_next;
            r_idx      <= w_idx_next;
            r_end_pend <= w_end_pend_next;
            r_out_d    <= w_out_d_next;
            r_out_e    <= w_out_e_next;
            r_out_v    <= w_out_v_next;
        end
    end

    assign out_d = r_out_d;
    assign out_e = r_out_e;
    assign out_v = r_out_v;

endmodule
